rv32i_multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I core. It replaces the single-cycle combinational decode with an FSM that steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB. It drives the same datapath controls as the single-cycle decoder, and adds IR load, PC enable and a request/acknowledge handshake to data memory. It sits between the instruction register and the datapath muxes, register file, PC and data RAM.

---
 rtl/rv32i_multicycle_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_rv32i_multicycle_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// rv32i_multicycle_ctrl
//
// Multi-cycle control sequencer for the RV32I core. Each instruction is stepped
// through FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB) -> FETCH. The block drives
// the datapath selects of the former single-cycle decoder. It also generates
// the IR load, the PC update strobe, and the data-memory request/acknowledge
// handshake, which includes a bounded wait with a trap on timeout.
//
// Ports:
//   iClk            system clock, rising edge
//   iRst            asynchronous active-high reset
//   iInst_Code      instruction register output (stable DECODE..next FETCH)
//   iBtaken         branch comparator result, sampled in EXECUTE
//   iData_Ack       data memory completion (pulse or level), used in MEM only
//   oIR_Load        latch instruction into IR (FETCH)
//   oPC_En          PC update strobe, one pulse per retired instruction
//   oPC_Sel         00 PC+4, 01 PC+imm, 10 rs1+imm
//   oFunct3         iInst_Code[14:12] passthrough (0 in IDLE/TRAP)
//   oALU_Control    ALU operation
//   oALUSrcMuxSel1  1 = PC as ALU operand A
//   oALUSrcMuxSel2  1 = immediate as ALU operand B
//   oRegWrDataSel   00 ALU, 01 load data, 10 imm, 11 PC+4
//   oWrEn           register file write strobe
//   oData_Req       data memory request
//   oData_WrEn      data memory write (only with oData_Req)
//   oRetire         retire pulse, coincident with oPC_En
//   oTrap           sticky fault flag (cleared only by iRst)
//   oState          current state, for debug
// -----------------------------------------------------------------------------
module rv32i_multicycle_ctrl #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iInst_Code,
  input  logic        iBtaken,
  input  logic        iData_Ack,
  output logic        oIR_Load,
  output logic        oPC_En,
  output logic [1:0]  oPC_Sel,
  output logic [2:0]  oFunct3,
  output logic [3:0]  oALU_Control,
  output logic        oALUSrcMuxSel1,
  output logic        oALUSrcMuxSel2,
  output logic [1:0]  oRegWrDataSel,
  output logic        oWrEn,
  output logic        oData_Req,
  output logic        oData_WrEn,
  output logic        oRetire,
  output logic        oTrap,
  output logic [2:0]  oState
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd7
  } state_t;

  // Counter value seen in the last permitted MEM cycle without an ack.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Instruction field decode
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7_b5;
  logic       is_r, is_i, is_il, is_s, is_b, is_lui, is_auipc, is_jal, is_jalr;
  logic       is_legal;

  assign opcode   = iInst_Code[6:0];
  assign funct3   = iInst_Code[14:12];
  assign f7_b5    = iInst_Code[30];

  assign is_r     = (opcode == 7'b0110011);
  assign is_i     = (opcode == 7'b0010011);
  assign is_il    = (opcode == 7'b0000011);
  assign is_s     = (opcode == 7'b0100011);
  assign is_b     = (opcode == 7'b1100011);
  assign is_lui   = (opcode == 7'b0110111);
  assign is_auipc = (opcode == 7'b0010111);
  assign is_jal   = (opcode == 7'b1101111);
  assign is_jalr  = (opcode == 7'b1100111);
  assign is_legal = is_r | is_i | is_il | is_s | is_b | is_lui | is_auipc | is_jal | is_jalr;

  // Register numbers and immediates are consumed by the datapath, not here.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{iInst_Code[31], iInst_Code[29:15], iInst_Code[11:7]};

  // ---------------------------------------------------------------------------
  // Datapath select decode (only presented in EXECUTE, MEM and WB)
  // ---------------------------------------------------------------------------
  logic [3:0] alu_dec;
  logic       sel1_dec, sel2_dec;
  logic [1:0] rwsel_dec;
  logic       dp_active;

  always_comb begin
    alu_dec = 4'b0000;
    if (is_r) begin
      alu_dec = {f7_b5, funct3};
    end else if (is_i) begin
      // Only the shift-right immediates use bit 30 to pick SRA vs SRL;
      // for other I-type ops that bit is part of the immediate.
      alu_dec = (funct3 == 3'b101) ? {f7_b5, funct3} : {1'b0, funct3};
    end else if (is_b) begin
      alu_dec = {1'b0, funct3};
    end
  end

  always_comb begin
    sel1_dec  = is_auipc;
    sel2_dec  = is_auipc | is_i | is_il | is_s | is_jalr;
    rwsel_dec = 2'b00;
    if (is_il) begin
      rwsel_dec = 2'b01;
    end else if (is_lui) begin
      rwsel_dec = 2'b10;
    end else if (is_jal || is_jalr) begin
      rwsel_dec = 2'b11;
    end
  end

  assign dp_active = (state_q == S_EXECUTE) || (state_q == S_MEM) || (state_q == S_WB);

  // ---------------------------------------------------------------------------
  // State and timeout counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control strobes
  // ---------------------------------------------------------------------------
  logic       ir_load, pc_en, wr_en, data_req, data_wren, trap;
  logic [1:0] pc_sel;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ir_load   = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = 2'b00;
    wr_en     = 1'b0;
    data_req  = 1'b0;
    data_wren = 1'b0;
    trap      = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        ir_load = 1'b1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        state_d = is_legal ? S_EXECUTE : S_TRAP;
      end

      S_EXECUTE: begin
        if (is_b) begin
          // Branches retire here; the PC takes the target or falls through.
          pc_en   = 1'b1;
          pc_sel  = iBtaken ? 2'b01 : 2'b00;
          state_d = S_FETCH;
        end else if (is_il || is_s) begin
          cnt_d   = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        data_req  = 1'b1;
        data_wren = is_s;
        // An ack always wins, even in the cycle that would otherwise time out.
        if (iData_Ack) begin
          if (is_s) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WB: begin
        wr_en   = 1'b1;
        pc_en   = 1'b1;
        if (is_jal) begin
          pc_sel = 2'b01;
        end else if (is_jalr) begin
          pc_sel = 2'b10;
        end
        state_d = S_FETCH;
      end

      S_TRAP: begin
        trap = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (all derived from the asynchronously reset state, so they fall to
  // zero as soon as iRst is asserted)
  // ---------------------------------------------------------------------------
  assign oIR_Load       = ir_load;
  assign oPC_En         = pc_en;
  assign oRetire        = pc_en;
  assign oPC_Sel        = pc_sel;
  assign oWrEn          = wr_en;
  assign oData_Req      = data_req;
  assign oData_WrEn     = data_wren;
  assign oTrap          = trap;
  assign oState         = state_q;
  assign oFunct3        = ((state_q == S_IDLE) || (state_q == S_TRAP)) ? 3'b000 : funct3;
  assign oALU_Control   = dp_active ? alu_dec   : 4'b0000;
  assign oALUSrcMuxSel1 = dp_active ? sel1_dec  : 1'b0;
  assign oALUSrcMuxSel2 = dp_active ? sel2_dec  : 1'b0;
  assign oRegWrDataSel  = dp_active ? rwsel_dec : 2'b00;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for rv32i_multicycle_ctrl. Each instruction is expanded by a
// reference model into its expected per-cycle output trace (phase list built
// from the instruction type), and the DUT is compared against it every cycle.
// -----------------------------------------------------------------------------
module tb_rv32i_multicycle_ctrl;

  localparam int TO = 16;

  localparam int T_R = 0, T_I = 1, T_IL = 2, T_S = 3, T_B = 4;
  localparam int T_LUI = 5, T_AUIPC = 6, T_JAL = 7, T_JALR = 8, T_ILL = 9;

  typedef struct packed {
    logic [2:0] st;
    logic       irl;
    logic       pcen;
    logic [1:0] pcs;
    logic [2:0] f3;
    logic [3:0] alu;
    logic       s1;
    logic       s2;
    logic [1:0] rws;
    logic       wr;
    logic       req;
    logic       dwr;
    logic       ret;
    logic       trp;
  } vec_t;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [31:0] iInst_Code = 32'h0;
  logic        iBtaken = 1'b0;
  logic        iData_Ack = 1'b0;
  logic        oIR_Load, oPC_En, oALUSrcMuxSel1, oALUSrcMuxSel2, oWrEn;
  logic        oData_Req, oData_WrEn, oRetire, oTrap;
  logic [1:0]  oPC_Sel, oRegWrDataSel;
  logic [2:0]  oFunct3, oState;
  logic [3:0]  oALU_Control;

  int total  = 0;
  int passed = 0;
  int retire_cnt = 0;
  int cyc_cnt    = 0;

  rv32i_multicycle_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .iClk           (iClk),
    .iRst           (iRst),
    .iInst_Code     (iInst_Code),
    .iBtaken        (iBtaken),
    .iData_Ack      (iData_Ack),
    .oIR_Load       (oIR_Load),
    .oPC_En         (oPC_En),
    .oPC_Sel        (oPC_Sel),
    .oFunct3        (oFunct3),
    .oALU_Control   (oALU_Control),
    .oALUSrcMuxSel1 (oALUSrcMuxSel1),
    .oALUSrcMuxSel2 (oALUSrcMuxSel2),
    .oRegWrDataSel  (oRegWrDataSel),
    .oWrEn          (oWrEn),
    .oData_Req      (oData_Req),
    .oData_WrEn     (oData_WrEn),
    .oRetire        (oRetire),
    .oTrap          (oTrap),
    .oState         (oState)
  );

  vec_t dut_vec;
  assign dut_vec = {oState, oIR_Load, oPC_En, oPC_Sel, oFunct3, oALU_Control,
                    oALUSrcMuxSel1, oALUSrcMuxSel2, oRegWrDataSel, oWrEn,
                    oData_Req, oData_WrEn, oRetire, oTrap};

  always #5 iClk = ~iClk;

  always @(posedge iClk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (oRetire) retire_cnt <= retire_cnt + 1;
  end

  // ---------------------------------------------------------------------------
  // Reference model helpers
  // ---------------------------------------------------------------------------
  function automatic int itype(input logic [31:0] inst);
    case (inst[6:0])
      7'b0110011: return T_R;
      7'b0010011: return T_I;
      7'b0000011: return T_IL;
      7'b0100011: return T_S;
      7'b1100011: return T_B;
      7'b0110111: return T_LUI;
      7'b0010111: return T_AUIPC;
      7'b1101111: return T_JAL;
      7'b1100111: return T_JALR;
      default:    return T_ILL;
    endcase
  endfunction

  function automatic logic [31:0] rand_inst(input int ty);
    logic [31:0] v;
    logic [6:0]  opc;
    v = $urandom;
    case (ty)
      T_R:     opc = 7'b0110011;
      T_I:     opc = 7'b0010011;
      T_IL:    opc = 7'b0000011;
      T_S:     opc = 7'b0100011;
      T_B:     opc = 7'b1100011;
      T_LUI:   opc = 7'b0110111;
      T_AUIPC: opc = 7'b0010111;
      T_JAL:   opc = 7'b1101111;
      default: opc = 7'b1100111;
    endcase
    v[6:0] = opc;
    return v;
  endfunction

  // Cycles from one FETCH to the next, straight from the CPI table.
  function automatic int model_cpi(input int ty, input int n_mem);
    if (ty == T_B) return 3;
    if (ty == T_S) return 3 + n_mem;
    if (ty == T_IL) return 4 + n_mem;
    return 4;
  endfunction

  // Drive one instruction starting at a falling edge where the DUT is in
  // FETCH, and compare every cycle of it. ack_at = MEM cycle (1-based) carrying
  // the ack; 0 means no ack ever (timeout, trace continues into TRAP).
  task automatic run_instr(input logic [31:0] inst, input logic bt,
                           input int ack_at, input string name);
    vec_t eq[$];
    bit   aq[$];
    vec_t dp, v;
    int   ty;
    bit   mem_op, is_b, is_s;
    ty     = itype(inst);
    is_b   = (ty == T_B);
    is_s   = (ty == T_S);
    mem_op = (ty == T_IL) || is_s;

    dp     = '0;
    dp.f3  = inst[14:12];
    case (ty)
      T_R:     dp.alu = {inst[30], inst[14:12]};
      T_I:     dp.alu = (inst[14:12] == 3'd5) ? {inst[30], inst[14:12]} : {1'b0, inst[14:12]};
      T_B:     dp.alu = {1'b0, inst[14:12]};
      default: dp.alu = 4'b0000;
    endcase
    dp.s1  = (ty == T_AUIPC);
    dp.s2  = (ty == T_AUIPC) || (ty == T_I) || (ty == T_IL) || is_s || (ty == T_JALR);
    dp.rws = (ty == T_IL) ? 2'b01 : (ty == T_LUI) ? 2'b10 :
             ((ty == T_JAL) || (ty == T_JALR)) ? 2'b11 : 2'b00;

    // FETCH and DECODE expose only funct3 (plus IR load in FETCH).
    v = '0; v.st = 3'd1; v.irl = 1'b1; v.f3 = inst[14:12];
    eq.push_back(v); aq.push_back(bit'($urandom_range(0, 1)));
    v = '0; v.st = 3'd2; v.f3 = inst[14:12];
    eq.push_back(v); aq.push_back(bit'($urandom_range(0, 1)));

    if (ty == T_ILL) begin
      v = '0; v.st = 3'd7; v.trp = 1'b1;
      repeat (4) begin eq.push_back(v); aq.push_back(bit'($urandom_range(0, 1))); end
    end else begin
      v = dp; v.st = 3'd3;
      if (is_b) begin
        v.pcen = 1'b1; v.ret = 1'b1; v.pcs = bt ? 2'b01 : 2'b00;
      end
      eq.push_back(v); aq.push_back(bit'($urandom_range(0, 1)));
      if (mem_op) begin
        for (int k = 1; k <= ((ack_at == 0) ? TO : ack_at); k++) begin
          v = dp; v.st = 3'd4; v.req = 1'b1; v.dwr = is_s;
          if (is_s && (k == ack_at)) begin v.pcen = 1'b1; v.ret = 1'b1; end
          eq.push_back(v); aq.push_back(k == ack_at);
        end
        if (ack_at == 0) begin
          v = '0; v.st = 3'd7; v.trp = 1'b1;
          repeat (4) begin eq.push_back(v); aq.push_back(bit'($urandom_range(0, 1))); end
        end
      end
      if (!is_b && !is_s && !(mem_op && ack_at == 0)) begin
        v = dp; v.st = 3'd5; v.wr = 1'b1; v.pcen = 1'b1; v.ret = 1'b1;
        v.pcs = (ty == T_JAL) ? 2'b01 : (ty == T_JALR) ? 2'b10 : 2'b00;
        eq.push_back(v); aq.push_back(bit'($urandom_range(0, 1)));
      end
    end

    iInst_Code = inst;
    iBtaken    = bt;
    for (int i = 0; i < eq.size(); i++) begin
      iData_Ack = aq[i];
      #1;
      total++;
      if (dut_vec !== eq[i])
        $display("FAIL %s inst=%h cycle %0d: got vec=%h (state %0d) expected vec=%h (state %0d)",
                 name, inst, i, dut_vec, dut_vec.st, eq[i], eq[i].st);
      else
        passed++;
      @(negedge iClk);
    end
    iData_Ack = 1'b0;
  endtask

  // Assert reset, check outputs are all zero while held and in IDLE after
  // release; leaves the bench at the falling edge where FETCH begins.
  task automatic apply_reset(input string name);
    iRst       = 1'b1;
    iData_Ack  = 1'b1;
    iInst_Code = $urandom;
    #1;
    total++;
    if (dut_vec !== vec_t'('0)) $display("FAIL %s_in_reset: got vec=%h expected 0", name, dut_vec);
    else passed++;
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    #1;
    total++;
    if (dut_vec !== vec_t'('0)) $display("FAIL %s_idle: got vec=%h expected 0", name, dut_vec);
    else passed++;
    iData_Ack = 1'b0;
    @(negedge iClk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge iClk);
    apply_reset("reset");
  endtask

  task automatic test_rtype();
    int r0, c0;
    r0 = retire_cnt; c0 = cyc_cnt;
    run_instr(32'h002081B3, 1'b0, 0, "add");
    run_instr(32'h002081B3, 1'b1, 0, "add2");
    total++;
    if ((retire_cnt - r0) != 2 || (cyc_cnt - c0) != 8)
      $display("FAIL add_cpi: got %0d retires in %0d cycles expected 2 in 8", retire_cnt - r0, cyc_cnt - c0);
    else passed++;
    run_instr(32'h402081B3, 1'b0, 0, "sub");
    run_instr(32'h4030D193, 1'b0, 0, "srai");
  endtask

  task automatic test_branch();
    run_instr(32'h00208463, 1'b1, 0, "beq_taken");
    run_instr(32'h00208463, 1'b0, 0, "beq_not_taken");
  endtask

  task automatic test_load_store();
    int c0;
    c0 = cyc_cnt;
    run_instr(32'h0000A183, 1'b0, 3, "lw_ack3");
    total++;
    if ((cyc_cnt - c0) != 7) $display("FAIL lw_cpi: got %0d expected 7", cyc_cnt - c0);
    else passed++;
    c0 = cyc_cnt;
    run_instr(32'h0030A023, 1'b0, 3, "sw_ack3");
    total++;
    if ((cyc_cnt - c0) != 6) $display("FAIL sw_cpi: got %0d expected 6", cyc_cnt - c0);
    else passed++;
    run_instr(32'h0030A023, 1'b0, 1, "sw_ack1");
  endtask

  task automatic test_timeout();
    run_instr(32'h0000A183, 1'b0, 0, "lw_timeout");
    apply_reset("after_timeout");
    run_instr(32'h0000A183, 1'b0, TO, "lw_ack_last");
    run_instr(32'h0030A023, 1'b0, 0, "sw_timeout");
    apply_reset("after_sw_timeout");
  endtask

  task automatic test_illegal();
    logic [31:0] ill;
    run_instr(32'h0000007F, 1'b0, 0, "illegal_7f");
    apply_reset("after_illegal");
    do ill = $urandom; while (itype(ill) != T_ILL);
    run_instr(ill, 1'b0, 0, "illegal_rand");
    apply_reset("after_illegal_rand");
  endtask

  task automatic test_reset_mid_mem();
    iInst_Code = 32'h0000A183;
    iData_Ack  = 1'b0;
    repeat (4) @(negedge iClk);  // FETCH, DECODE, EXECUTE, then MEM
    #1;
    total++;
    if (oState !== 3'd4 || oData_Req !== 1'b1)
      $display("FAIL mid_mem_pre: got state=%0d req=%b expected state=4 req=1", oState, oData_Req);
    else passed++;
    @(posedge iClk);             // still MEM, timeout far away
    #2;
    iRst = 1'b1;
    #1;
    total++;
    if (oData_Req !== 1'b0 || oState !== 3'd0)
      $display("FAIL mid_mem_async: got req=%b state=%0d expected req=0 state=0", oData_Req, oState);
    else passed++;
    iData_Ack = 1'b1;            // late ack while in reset/IDLE must be ignored
    @(negedge iClk);
    apply_reset("mid_mem");
    run_instr(32'h002081B3, 1'b0, 0, "add_after_mid_reset");
  endtask

  task automatic test_back_to_back();
    int r0, c0, exp_cyc, n;
    r0 = retire_cnt; c0 = cyc_cnt; exp_cyc = 0; n = 40;
    for (int i = 0; i < n; i++) begin
      int ty, ack_at;
      logic [31:0] inst;
      ty     = $urandom_range(T_R, T_JALR);
      inst   = rand_inst(ty);
      ack_at = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(1, 5);
      run_instr(inst, 1'($urandom_range(0, 1)), ack_at, "random");
      exp_cyc += model_cpi(ty, ack_at);
    end
    total++;
    if ((retire_cnt - r0) != n) $display("FAIL b2b_retires: got %0d expected %0d", retire_cnt - r0, n);
    else passed++;
    total++;
    if ((cyc_cnt - c0) != exp_cyc) $display("FAIL b2b_cycles: got %0d expected %0d", cyc_cnt - c0, exp_cyc);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_branch();
    test_load_store();
    test_timeout();
    test_illegal();
    test_reset_mid_mem();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
